// File: rtl/pipe_stage_reg.sv
// Chain of STAGES pipeline-register slots. Each slot is a main register plus a one-entry skid buffer.
// The chain has valid/ready handshakes, flush with bubble insertion, a run-enable freeze and an occupancy count.
module pipe_stage_reg #(
    parameter int CTRL_W = 2,
    parameter int DATA_W = 69,
    parameter int STAGES = 1,
    parameter int OCC_W  = 4
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              start_i,
    input  logic              flush_i,
    input  logic              valid_i,
    output logic              ready_o,
    input  logic [CTRL_W-1:0] ctrl_i,
    input  logic [DATA_W-1:0] data_i,
    output logic              valid_o,
    input  logic              ready_i,
    output logic [CTRL_W-1:0] ctrl_o,
    output logic [DATA_W-1:0] data_o,
    output logic [OCC_W-1:0]  occ_o
);

    logic              w_up_v    [STAGES];
    logic [CTRL_W-1:0] w_up_ctrl [STAGES];
    logic [DATA_W-1:0] w_up_data [STAGES];
    logic              w_dn_rdy  [STAGES];
    logic              w_m_v     [STAGES];
    logic              w_s_v     [STAGES];
    logic [CTRL_W-1:0] w_m_ctrl  [STAGES];
    logic [DATA_W-1:0] w_m_data  [STAGES];

    logic              w_accept;
    logic              w_emit;
    logic [OCC_W-1:0]  r_occ;

    genvar gi;
    generate
        for (gi = 0; gi < STAGES; gi++) begin : g_slot
            logic              r_m_v;
            logic              r_s_v;
            logic [CTRL_W-1:0] r_m_ctrl;
            logic [CTRL_W-1:0] r_s_ctrl;
            logic [DATA_W-1:0] r_m_data;
            logic [DATA_W-1:0] r_s_data;
            logic              w_acc;
            logic              w_out;

            if (gi == 0) begin : g_first
                assign w_up_v[gi]    = valid_i;
                assign w_up_ctrl[gi] = ctrl_i;
                assign w_up_data[gi] = data_i;
            end else begin : g_chain
                assign w_up_v[gi]    = w_m_v[gi-1];
                assign w_up_ctrl[gi] = w_m_ctrl[gi-1];
                assign w_up_data[gi] = w_m_data[gi-1];
            end

            // Downstream ready between slots is the neighbour's registered skid-empty flag.
            if (gi == STAGES - 1) begin : g_last
                assign w_dn_rdy[gi] = ready_i;
            end else begin : g_mid
                assign w_dn_rdy[gi] = ~w_s_v[gi+1];
            end

            assign w_acc = start_i & w_up_v[gi] & ~r_s_v;
            assign w_out = start_i & r_m_v & w_dn_rdy[gi];

            always_ff @(posedge clk_i or negedge rst_n_i) begin
                if (!rst_n_i) begin
                    r_m_v    <= 1'b0;
                    r_s_v    <= 1'b0;
                    r_m_ctrl <= '0;
                    r_s_ctrl <= '0;
                    r_m_data <= '0;
                    r_s_data <= '0;
                end else if (start_i) begin
                    if (flush_i) begin
                        r_m_v    <= 1'b0;
                        r_s_v    <= 1'b0;
                        r_m_ctrl <= '0;
                        r_s_ctrl <= '0;
                    end else if (!r_m_v || w_out) begin
                        // Skid drains before any new upstream entry to keep FIFO order.
                        if (r_s_v) begin
                            r_m_v    <= 1'b1;
                            r_m_ctrl <= r_s_ctrl;
                            r_m_data <= r_s_data;
                            r_s_v    <= 1'b0;
                        end else if (w_acc) begin
                            r_m_v    <= 1'b1;
                            r_m_ctrl <= w_up_ctrl[gi];
                            r_m_data <= w_up_data[gi];
                        end else begin
                            r_m_v    <= 1'b0;
                        end
                    end else if (w_acc) begin
                        r_s_v    <= 1'b1;
                        r_s_ctrl <= w_up_ctrl[gi];
                        r_s_data <= w_up_data[gi];
                    end
                end
            end

            assign w_m_v[gi]    = r_m_v;
            assign w_s_v[gi]    = r_s_v;
            assign w_m_ctrl[gi] = r_m_ctrl;
            assign w_m_data[gi] = r_m_data;
        end
    endgenerate

    assign ready_o = ~w_s_v[0] & start_i & rst_n_i;
    assign valid_o = w_m_v[STAGES-1];
    assign ctrl_o  = valid_o ? w_m_ctrl[STAGES-1] : '0;
    assign data_o  = w_m_data[STAGES-1];

    assign w_accept = valid_i & ready_o;
    assign w_emit   = valid_o & ready_i & start_i;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_occ <= '0;
        end else if (start_i) begin
            if (flush_i) begin
                r_occ <= '0;
            end else begin
                r_occ <= r_occ + OCC_W'(w_accept) - OCC_W'(w_emit);
            end
        end
    end

    assign occ_o = r_occ;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: a 1-stage and a 4-stage instance share one stimulus stream.
// Each instance is checked every cycle against a queue model in which every entry carries its slot position.
module tb_pipe_stage_reg;
    localparam int CW = 2;
    localparam int DW = 69;
    localparam int OW = 4;
    localparam int ND = 2;

    logic clk_i;
    logic rst_n_i, start_i, flush_i, valid_i, ready_i;
    logic [CW-1:0] ctrl_i;
    logic [DW-1:0] data_i;
    logic          ready_o [ND];
    logic          valid_o [ND];
    logic [CW-1:0] ctrl_o  [ND];
    logic [DW-1:0] data_o  [ND];
    logic [OW-1:0] occ_o   [ND];

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    pipe_stage_reg #(.CTRL_W(CW), .DATA_W(DW), .STAGES(1), .OCC_W(OW)) u_dut_s1 (
        .clk_i(clk_i), .rst_n_i(rst_n_i), .start_i(start_i), .flush_i(flush_i),
        .valid_i(valid_i), .ready_o(ready_o[0]), .ctrl_i(ctrl_i), .data_i(data_i),
        .valid_o(valid_o[0]), .ready_i(ready_i), .ctrl_o(ctrl_o[0]), .data_o(data_o[0]),
        .occ_o(occ_o[0])
    );

    pipe_stage_reg #(.CTRL_W(CW), .DATA_W(DW), .STAGES(4), .OCC_W(OW)) u_dut_s4 (
        .clk_i(clk_i), .rst_n_i(rst_n_i), .start_i(start_i), .flush_i(flush_i),
        .valid_i(valid_i), .ready_o(ready_o[1]), .ctrl_i(ctrl_i), .data_i(data_i),
        .valid_o(valid_o[1]), .ready_i(ready_i), .ctrl_o(ctrl_o[1]), .data_o(data_o[1]),
        .occ_o(occ_o[1])
    );

    typedef struct {
        int          d;
        int          pos;
        logic [CW-1:0] ctrl;
        logic [DW-1:0] data;
    } ent_t;

    ent_t mq[$];
    int n_checks = 0;
    int n_fail   = 0;

    function automatic int stages_of(input int d);
        return (d == 0) ? 1 : 4;
    endfunction

    function automatic int slot_cnt(input int d, input int k);
        int c;
        c = 0;
        for (int i = 0; i < mq.size(); i++)
            if (mq[i].d == d && mq[i].pos == k) c++;
        return c;
    endfunction

    function automatic int occ_of(input int d);
        int c;
        c = 0;
        for (int i = 0; i < mq.size(); i++)
            if (mq[i].d == d) c++;
        return c;
    endfunction

    function automatic int head_idx(input int d);
        int h;
        h = -1;
        for (int i = mq.size() - 1; i >= 0; i--)
            if (mq[i].d == d) h = i;
        return h;
    endfunction

    // Each slot holds at most two entries; all moves use pre-edge slot counts.
    task automatic model_step(input int d);
        int   ns;
        int   c[4];
        bit   moved;
        ent_t e;
        ns = stages_of(d);
        for (int k = 0; k < 4; k++) c[k] = (k < ns) ? slot_cnt(d, k) : 0;
        if (!start_i) return;
        if (flush_i) begin
            for (int i = mq.size() - 1; i >= 0; i--)
                if (mq[i].d == d) mq.delete(i);
            return;
        end
        if (ready_i && c[ns-1] > 0) mq.delete(head_idx(d));
        for (int k = ns - 2; k >= 0; k--) begin
            if (c[k] > 0 && c[k+1] < 2) begin
                moved = 1'b0;
                for (int i = 0; i < mq.size(); i++) begin
                    if (!moved && mq[i].d == d && mq[i].pos == k) begin
                        mq[i].pos = k + 1;
                        moved = 1'b1;
                    end
                end
            end
        end
        if (valid_i && c[0] < 2) begin
            e.d = d; e.pos = 0; e.ctrl = ctrl_i; e.data = data_i;
            mq.push_back(e);
        end
    endtask

    always @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) mq.delete();
        else for (int d = 0; d < ND; d++) model_step(d);
    end

    task automatic chk(input string name, input int d, input logic [71:0] act, input logic [71:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s dut%0d: got %h expected %h at %0t", name, d, act, exp, $time);
        end
    endtask

    bit            have_prev [ND];
    logic [DW-1:0] prev_data [ND];

    initial begin
        int h;
        bit ev;
        for (int d = 0; d < ND; d++) have_prev[d] = 1'b0;
        forever begin
            @(negedge clk_i);
            for (int d = 0; d < ND; d++) begin
                h  = head_idx(d);
                ev = (h >= 0) && (mq[h].pos == stages_of(d) - 1);
                chk("valid_o", d, 72'(valid_o[d]), 72'(ev));
                chk("ctrl_o", d, 72'(ctrl_o[d]), ev ? 72'(mq[h].ctrl) : 72'(0));
                chk("occ_o", d, 72'(occ_o[d]), 72'(occ_of(d)));
                chk("ready_o", d, 72'(ready_o[d]), 72'(rst_n_i && start_i && (slot_cnt(d, 0) < 2)));
                if (ev) chk("data_o", d, 72'(data_o[d]), 72'(mq[h].data));
                else if (have_prev[d] && rst_n_i) chk("data_hold", d, 72'(data_o[d]), 72'(prev_data[d]));
                have_prev[d] = rst_n_i;
                prev_data[d] = data_o[d];
            end
        end
    end

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic drain();
        valid_i = 1'b0; ready_i = 1'b1; flush_i = 1'b0; start_i = 1'b1;
        repeat (12) step();
    endtask

    initial begin
        logic [95:0] r96;
        int rdy_pct;
        int e0, e1;
        rst_n_i = 1'b0; start_i = 1'b0; flush_i = 1'b0; valid_i = 1'b0;
        ready_i = 1'b0; ctrl_i = '0; data_i = '0;
        repeat (2) step();
        for (int d = 0; d < ND; d++) begin
            chk("rst_ready", d, 72'(ready_o[d]), 72'(0));
            chk("rst_occ", d, 72'(occ_o[d]), 72'(0));
        end
        rst_n_i = 1'b1; start_i = 1'b1;
        step();
        for (int d = 0; d < ND; d++) begin
            chk("post_rst_ready", d, 72'(ready_o[d]), 72'(1));
            chk("post_rst_valid", d, 72'(valid_o[d]), 72'(0));
        end

        // Continuous stream, no backpressure
        ctrl_i = 2'b11; ready_i = 1'b1; valid_i = 1'b1;
        for (int i = 0; i < 10; i++) begin
            data_i = DW'(i);
            step();
            chk("stream_data", 0, 72'(data_o[0]), 72'(i));
            chk("stream_occ", 0, 72'(occ_o[0]), 72'(1));
            chk("stream_ready", 0, 72'(ready_o[0]), 72'(1));
            if (i == 2) chk("s4_latency_early", 1, 72'(valid_o[1]), 72'(0));
            if (i == 3) chk("s4_latency_data", 1, 72'(data_o[1]), 72'(0));
        end
        drain();

        // Backpressure fill to capacity
        ctrl_i = 2'b01; ready_i = 1'b0; valid_i = 1'b1;
        for (int i = 0; i < 12; i++) begin
            data_i = DW'(32'h100 + i);
            step();
            e0 = (i + 1 < 2) ? i + 1 : 2;
            e1 = (i + 1 < 8) ? i + 1 : 8;
            chk("bp_occ", 0, 72'(occ_o[0]), 72'(e0));
            chk("bp_occ", 1, 72'(occ_o[1]), 72'(e1));
            chk("bp_ready", 0, 72'(ready_o[0]), 72'(i < 1));
            chk("bp_ready", 1, 72'(ready_o[1]), 72'(i < 7));
        end
        chk("bp_head", 0, 72'(data_o[0]), 72'(32'h100));
        chk("bp_head", 1, 72'(data_o[1]), 72'(32'h100));
        valid_i = 1'b0; ready_i = 1'b1;
        step();
        chk("bp_second", 0, 72'(data_o[0]), 72'(32'h101));
        chk("bp_second", 1, 72'(data_o[1]), 72'(32'h101));
        valid_i = 1'b1;
        for (int i = 0; i < 8; i++) begin
            data_i = DW'(32'h10C + i);
            step();
        end
        drain();

        // Flush with a same-cycle input that must be dropped
        ctrl_i = 2'b10; ready_i = 1'b1; valid_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            data_i = DW'(32'h200 + i);
            step();
        end
        chk("pre_flush_occ", 1, 72'(occ_o[1]), 72'(4));
        flush_i = 1'b1; data_i = DW'(8'hAA);
        step();
        flush_i = 1'b0; valid_i = 1'b0;
        for (int d = 0; d < ND; d++) begin
            chk("flush_occ", d, 72'(occ_o[d]), 72'(0));
            chk("flush_valid", d, 72'(valid_o[d]), 72'(0));
            chk("flush_ctrl", d, 72'(ctrl_o[d]), 72'(0));
        end
        for (int i = 0; i < 6; i++) begin
            step();
            chk("flush_no_aa", 1, 72'(valid_o[1] && data_o[1] == DW'(8'hAA)), 72'(0));
        end
        drain();

        // Freeze with an ignored flush pulse
        ctrl_i = 2'b11; ready_i = 1'b1; valid_i = 1'b1;
        for (int i = 0; i < 6; i++) begin
            data_i = DW'(32'h300 + i);
            step();
        end
        for (int f = 0; f < 3; f++) begin
            start_i = 1'b0; flush_i = (f == 1); valid_i = f[0];
            step();
            chk("frz_ready", 0, 72'(ready_o[0]), 72'(0));
            chk("frz_ready", 1, 72'(ready_o[1]), 72'(0));
            chk("frz_occ", 0, 72'(occ_o[0]), 72'(1));
            chk("frz_occ", 1, 72'(occ_o[1]), 72'(4));
            chk("frz_data", 0, 72'(data_o[0]), 72'(32'h305));
            chk("frz_data", 1, 72'(data_o[1]), 72'(32'h302));
        end
        start_i = 1'b1; flush_i = 1'b0; valid_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            data_i = DW'(32'h306 + i);
            step();
        end
        drain();

        // Asynchronous reset between edges
        ctrl_i = 2'b11; ready_i = 1'b1; valid_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            data_i = DW'(32'h400 + i);
            step();
        end
        valid_i = 1'b0;
        step();
        chk("pre_rst_occ", 1, 72'(occ_o[1]), 72'(3));
        chk("pre_rst_data", 1, 72'(data_o[1]), 72'(32'h401));
        #2;
        rst_n_i = 1'b0;
        #1;
        for (int d = 0; d < ND; d++) begin
            chk("arst_valid", d, 72'(valid_o[d]), 72'(0));
            chk("arst_ctrl", d, 72'(ctrl_o[d]), 72'(0));
            chk("arst_occ", d, 72'(occ_o[d]), 72'(0));
            chk("arst_ready", d, 72'(ready_o[d]), 72'(0));
        end
        @(posedge clk_i);
        @(posedge clk_i);
        #3;
        rst_n_i = 1'b1; start_i = 1'b1;
        step();
        for (int d = 0; d < ND; d++) chk("arst_release_ready", d, 72'(ready_o[d]), 72'(1));

        // Randomized traffic with varying backpressure
        rdy_pct = 50;
        for (int n = 0; n < 10000; n++) begin
            if (n % 500 == 0) rdy_pct = (n / 500 % 3 == 0) ? 20 : ((n / 500 % 3 == 1) ? 50 : 90);
            r96     = {$urandom(), $urandom(), $urandom()};
            data_i  = r96[DW-1:0];
            ctrl_i  = CW'($urandom_range(0, 3));
            valid_i = ($urandom_range(0, 3) != 0);
            ready_i = ($urandom_range(0, 99) < rdy_pct);
            start_i = ($urandom_range(0, 99) >= 3);
            flush_i = ($urandom_range(0, 199) == 0);
            step();
        end
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/pipe_stage_reg.md
Name: pipe_stage_reg

Overview:
Parametrised successor to the fixed MEM/WB-style latch. It is a chain of STAGES pipeline-register slots, each carrying a control field and a data field, with a valid/ready handshake and a one-entry skid buffer per slot. It adds stall and backpressure, flush with bubble insertion, and an occupancy count. It sits between any two pipeline stages of the CPU, for example MEM to WB or ID to EX.

Parameters:
CTRL_W, 2, control-bit width (e.g. MemtoReg and RegWrite); zeroed on flush and on bubbles.
DATA_W, 69, payload width (e.g. ALUResult 32 + MemData 32 + RegAddr 5); never cleared except by reset.
STAGES, 1, number of chained slots; legal range 1..4; latency in cycles.
OCC_W, 4, occupancy counter width; must satisfy 2^OCC_W > 2*STAGES.

Ports:
clk_i  in  1  clock; all state updates on posedge.
rst_n_i  in  1  asynchronous active-low reset.
start_i  in  1  global run enable; low freezes all state.
flush_i  in  1  synchronous flush; kills every in-flight entry.
valid_i  in  1  upstream entry valid.
ready_o  out  1  this block can accept an entry this cycle.
ctrl_i  in  CTRL_W  upstream control bits.
data_i  in  DATA_W  upstream payload.
valid_o  out  1  downstream entry valid.
ready_i  in  1  downstream accepts this cycle.
ctrl_o  out  CTRL_W  control bits; forced to 0 whenever valid_o=0.
data_o  out  DATA_W  payload of the head entry; value is don't-care when valid_o=0 but is held stable.
occ_o  out  OCC_W  number of valid entries held, counting main and skid registers.

Behaviour:
- Reset (rst_n_i=0, asynchronous):
  - All valid bits, ctrl registers, data registers and occ_o go to 0.
  - ready_o=0 while reset is asserted.
  - Reset asserted mid-operation discards all entries immediately, with no clock edge required.
- Handshakes:
  - Accept occurs when valid_i & ready_o & start_i.
  - Emit occurs when valid_o & ready_i & start_i.
  - Both may happen in the same cycle.
- Slot structure: each slot k has a main register (m_v, m_ctrl, m_data) and a skid register (s_v, s_ctrl, s_data).
  - Slot k's upstream is slot k-1; slot 0's upstream is the input port.
  - The last slot drives the output port.
- Slot ready: slot_ready_k = !s_v_k. It is a registered value, so there is no combinational path from ready_i to ready_o. ready_o = slot_ready_0 & start_i & rst_n_i.
- Slot update per cycle:
  - If the main register is empty or is emitting downstream, it loads from the skid register if s_v=1, otherwise from upstream.
  - If the main register is full and stalled, an upstream accept goes into the skid register.
  - The skid register drains first, preserving FIFO order.
- Latency and throughput:
  - With no backpressure, latency is exactly STAGES cycles from accept to valid_o.
  - Throughput is one entry per cycle.
  - Full throughput holds under continuous ready_i=1.
- Backpressure:
  - ready_i=0 fills the slots in turn.
  - ready_o drops exactly on the cycle after slot 0's skid register fills.
  - Capacity is 2*STAGES entries; no entry is ever dropped or duplicated.
- Flush (flush_i=1 and start_i=1):
  - At the next edge all m_v/s_v clear, all ctrl registers clear to 0, and occ_o becomes 0. Data registers keep their values.
  - Flush has priority over a same-cycle accept: that input entry is dropped.
  - A same-cycle emit still counts as delivered downstream, because the output is observed before the edge.
- Freeze (start_i=0):
  - No register changes; ready_o=0 and flush_i is ignored.
  - valid_o, ctrl_o and data_o continue to reflect the held head entry.
  - ready_i is ignored, because emit requires start_i.
- Occupancy: occ_o = occ_o + accept - emit, or 0 on flush. It is registered, never exceeds 2*STAGES, and never underflows.
- Bubbles: ctrl_o = valid_o ? head ctrl : 0. A bubble therefore never presents RegWrite=1 downstream.

Test Plan:
- STAGES=1, continuous stream of ctrl=2'b11 with data=0,1,2,…,9, ready_i=1 → valid_o one cycle later, data_o=0..9 in order with no gaps, occ_o=1 steady, ready_o=1 throughout.
- STAGES=3, send A,B,C,… with ready_i held low → ready_o falls after 6 entries and occ_o=6. Then set ready_i=1 → A..F emerge in order, then new entries follow with no loss.
- STAGES=2, 4 entries in flight, pulse flush_i with valid_i=1 (data 0xAA) → next cycle occ_o=0, valid_o=0, ctrl_o=0, and 0xAA never appears at the output.
- STAGES=2, mid-stream drop start_i for 3 cycles → outputs held, occ_o held, ready_o=0, flush_i pulse ignored. Stream then resumes in order.
- Assert rst_n_i asynchronously between clock edges with occ_o=3 → valid_o=0, ctrl_o=0, occ_o=0 and ready_o=0 immediately. After release, ready_o=1 on the first edge with start_i=1.
- Random valid_i/ready_i toggling (10k cycles, STAGES=4) against a reference FIFO model → order preserved, occ_o matches the model, no ready_i→ready_o combinational path (check with lint/STA).
